switch_box_config_loader: RTL and testbench

Serial configuration writer and readback port for one unidirectional switch box. Accepts a bit stream over a valid/ready handshake into a shadow register, then commits it atomically to the active configuration word that drives the switch box's routing muxes. The routing fabric never sees a partial configuration. Also supports serial readback of the active word for bitstream verification, and a registered scan-out for daisy-chaining loaders.

---
 rtl/sb_cfg_pkg.sv | 21 ++
 rtl/sb_cfg_shift_reg.sv | 42 ++++
 rtl/switch_box_config_loader.sv | 157 +++++++++++++++
 tb/tb_switch_box_config_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// ============================================================================
// sb_cfg_pkg : shared types and defaults for the switch-box config loader
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sb_cfg_pkg;

    // 5x7 track switch box
    localparam int c_CFG_W_DEFAULT = 35;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        COMMIT   = 2'd2,
        READBACK = 2'd3
    } sb_state_e;

endpackage

`default_nettype wire

// File: rtl/sb_cfg_shift_reg.sv
// ============================================================================
// sb_cfg_shift_reg : shadow register with serial-in, parallel load, serial-out
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sb_cfg_shift_reg
    import sb_cfg_pkg::*;
#(
    parameter int CFG_W = c_CFG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_in,
    input  logic             shift_in_bit,
    input  logic             load,
    input  logic [CFG_W-1:0] load_data,
    input  logic             shift_out,
    output logic [CFG_W-1:0] shadow,
    output logic             tap
);

    logic [CFG_W-1:0] r_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (load) begin
            r_shadow <= load_data;
        end else if (shift_in) begin
            r_shadow <= {shift_in_bit, r_shadow[CFG_W-1:1]};
        end else if (shift_out) begin
            r_shadow <= {1'b0, r_shadow[CFG_W-1:1]};
        end
    end

    assign shadow = r_shadow;
    assign tap    = r_shadow[0];

endmodule

`default_nettype wire

// File: rtl/switch_box_config_loader.sv
// ============================================================================
// switch_box_config_loader : serial config load, atomic commit and readback
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module switch_box_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int CFG_W = c_CFG_W_DEFAULT,
    parameter int CNT_W = $clog2(CFG_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_out,
    output logic [CFG_W-1:0] cfg_bits,
    output logic             cfg_done,
    input  logic             rb_start,
    output logic             rb_data,
    output logic             rb_valid,
    input  logic             rb_ready
);

    localparam logic [1:0]       c_IDLE     = 2'(IDLE);
    localparam logic [1:0]       c_SHIFT    = 2'(SHIFT);
    localparam logic [1:0]       c_COMMIT   = 2'(COMMIT);
    localparam logic [1:0]       c_READBACK = 2'(READBACK);
    localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(CFG_W - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [CFG_W-1:0] r_cfg_bits;
    logic             r_cfg_out;
    logic             r_cfg_done;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_shift_in;
    logic             w_load;
    logic             w_shift_out;
    logic             w_commit;
    logic             w_done_clr;
    logic [CFG_W-1:0] w_shadow;
    logic             w_tap;

    sb_cfg_shift_reg #(
        .CFG_W (CFG_W)
    ) u_shadow (
        .clk          (clk),
        .rst_n        (rst_n),
        .shift_in     (w_shift_in),
        .shift_in_bit (cfg_in),
        .load         (w_load),
        .load_data    (r_cfg_bits),
        .shift_out    (w_shift_out),
        .shadow       (w_shadow),
        .tap          (w_tap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_shift_in  = 1'b0;
        w_load      = 1'b0;
        w_shift_out = 1'b0;
        w_commit    = 1'b0;
        w_done_clr  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = c_SHIFT;
                    w_count_nxt = '0;
                    w_done_clr  = 1'b1;
                end else if (rb_start) begin
                    w_state_nxt = c_READBACK;
                    w_count_nxt = '0;
                    w_load      = 1'b1;
                end
            end
            c_SHIFT: begin
                // abort wins over a same-cycle accept; that bit is dropped
                if (cfg_abort) begin
                    w_state_nxt = c_IDLE;
                end else if (cfg_valid) begin
                    w_shift_in = 1'b1;
                    if (r_count == c_LAST) begin
                        w_state_nxt = c_COMMIT;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            c_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = c_IDLE;
            end
            c_READBACK: begin
                if (cfg_start) begin
                    w_state_nxt = c_SHIFT;
                    w_count_nxt = '0;
                    w_done_clr  = 1'b1;
                end else if (rb_ready) begin
                    w_shift_out = 1'b1;
                    if (r_count == c_LAST) begin
                        w_state_nxt = c_IDLE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_cfg_bits <= '0;
            r_cfg_out  <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_shift_in) begin
                r_cfg_out <= w_tap;
            end
            // the only edge at which the routing fabric sees a new word
            if (w_commit) begin
                r_cfg_bits <= w_shadow;
                r_cfg_done <= 1'b1;
            end else if (w_done_clr) begin
                r_cfg_done <= 1'b0;
            end
        end
    end

    assign cfg_ready = (r_state == c_SHIFT);
    assign rb_valid  = (r_state == c_READBACK);
    assign rb_data   = w_tap;
    assign cfg_out   = r_cfg_out;
    assign cfg_bits  = r_cfg_bits;
    assign cfg_done  = r_cfg_done;

endmodule

`default_nettype wire

// File: tb/tb_switch_box_config_loader.sv
// ============================================================================
// tb_switch_box_config_loader : randomized self-checking bench, CFG_W = 8
// Revision                    : 1.0
// ============================================================================
`default_nettype none

module tb_switch_box_config_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    always #5 clk = ~clk;

    logic         cfg_start, cfg_abort, cfg_in, cfg_valid, rb_start, rb_ready;
    logic         cfg_ready, cfg_out, cfg_done, rb_data, rb_valid;
    logic [W-1:0] cfg_bits;

    logic         a_start, a_valid, a_in;
    logic         a_ready, a_out, a_done, a_rb_data, a_rb_valid;
    logic [W-1:0] a_bits;
    logic         b_ready, b_out, b_done, b_rb_data, b_rb_valid;
    logic [W-1:0] b_bits;
    logic         a_acc_d;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_bits;

    switch_box_config_loader #(.CFG_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_in(cfg_in), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_out(cfg_out),
        .cfg_bits(cfg_bits), .cfg_done(cfg_done), .rb_start(rb_start), .rb_data(rb_data),
        .rb_valid(rb_valid), .rb_ready(rb_ready)
    );

    // daisy chain: b samples a's scan-out one cycle after each a accept
    switch_box_config_loader #(.CFG_W(W)) u_a (
        .clk(clk), .rst_n(rst_n), .cfg_start(a_start), .cfg_abort(1'b0),
        .cfg_in(a_in), .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_out(a_out),
        .cfg_bits(a_bits), .cfg_done(a_done), .rb_start(1'b0), .rb_data(a_rb_data),
        .rb_valid(a_rb_valid), .rb_ready(1'b0)
    );

    switch_box_config_loader #(.CFG_W(W)) u_b (
        .clk(clk), .rst_n(rst_n), .cfg_start(a_start), .cfg_abort(1'b0),
        .cfg_in(a_out), .cfg_valid(a_acc_d), .cfg_ready(b_ready), .cfg_out(b_out),
        .cfg_bits(b_bits), .cfg_done(b_done), .rb_start(1'b0), .rb_data(b_rb_data),
        .rb_valid(b_rb_valid), .rb_ready(1'b0)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_acc_d <= 1'b0;
        else        a_acc_d <= a_valid & a_ready;
    end

    // word built from a serial stream, first bit = LSB
    function automatic logic [W-1:0] pack_stream(input bit q[$]);
        logic [W-1:0] w = '0;
        for (int i = 0; i < q.size() && i < W; i++) w = w | (W'(q[i]) << i);
        return w;
    endfunction

    task automatic do_start();
        @(negedge clk); cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
    endtask

    // sends n bits of w; returns at the negedge just after the n-th accept
    task automatic send_bits(input logic [W-1:0] w, input int n, input int gap_pct);
        bit v;
        for (int i = 0; i < n; i++) begin
            do begin
                v         = ($urandom_range(99) >= gap_pct);
                cfg_valid = v;
                cfg_in    = v ? w[i] : 1'($urandom);
                @(negedge clk);
            end while (!v);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (cfg_bits !== 8'h00) begin n_err++; $display("FAIL reset_bits: got %h want 00", cfg_bits); end
        n_vec++; if ({cfg_done, cfg_ready, cfg_out, rb_valid, rb_data} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", {cfg_done, cfg_ready, cfg_out, rb_valid, rb_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", cfg_ready); end
        exp_bits = '0;
    endtask

    task automatic test_load_continuous();
        bit q[$] = '{1, 0, 1, 1, 0, 0, 1, 0};
        logic [W-1:0] w = pack_stream(q);
        do_start();
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL shift_ready: got %b want 1", cfg_ready); end
        send_bits(w, W, 0);
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL commit_ready: got %b want 0", cfg_ready); end
        n_vec++; if (cfg_bits !== exp_bits) begin n_err++; $display("FAIL pre_commit_bits: got %h want %h", cfg_bits, exp_bits); end
        @(negedge clk);
        exp_bits = w;
        n_vec++; if (cfg_bits !== 8'h4D) begin n_err++; $display("FAIL load_4d: got %h want 4d", cfg_bits); end
        n_vec++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL load_done: got %b want 1", cfg_done); end
    endtask

    task automatic test_load_gapped();
        bit q[$] = '{1, 0, 1, 1, 0, 0, 1, 0};
        logic [W-1:0] w = pack_stream(q);
        logic [W-1:0] old = exp_bits;
        do_start();
        for (int i = 0; i < W; i++) begin
            cfg_valid = 1'b0; cfg_in = 1'($urandom);
            @(negedge clk);
            n_vec++; if (cfg_bits !== old || cfg_done !== 1'b0) begin
                n_err++; $display("FAIL gap_hold bit%0d: got %h/%b want %h/0", i, cfg_bits, cfg_done, old);
            end
            cfg_valid = 1'b1; cfg_in = w[i];
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL gap_early_done: got %b want 0", cfg_done); end
        @(negedge clk);
        exp_bits = w;
        n_vec++; if (cfg_bits !== 8'h4D || cfg_done !== 1'b1) begin
            n_err++; $display("FAIL gap_commit: got %h/%b want 4d/1", cfg_bits, cfg_done);
        end
    endtask

    task automatic test_abort();
        do_start();
        send_bits(8'($urandom), 5, 0);
        cfg_valid = 1'b1; cfg_in = 1'b1; cfg_abort = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_abort = 1'b0;
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL abort_idle: got ready %b want 0", cfg_ready); end
        n_vec++; if (cfg_bits !== exp_bits) begin n_err++; $display("FAIL abort_bits: got %h want %h", cfg_bits, exp_bits); end
        repeat (10) @(negedge clk);
        n_vec++; if (cfg_bits !== exp_bits || cfg_done !== 1'b0) begin
            n_err++; $display("FAIL abort_later: got %h/%b want %h/0", cfg_bits, cfg_done, exp_bits);
        end
    endtask

    // directed: stall 3 cycles on bit 2; random: random stalls
    task automatic test_readback(input bit rand_stall, input logic exp_done);
        int   idx = 0, cyc = 0, stalls = 0;
        logic prev;
        @(negedge clk); rb_start = 1'b1;
        @(negedge clk); rb_start = 1'b0;
        while (idx < W && cyc < 200) begin
            n_vec++; if (rb_valid !== 1'b1 || rb_data !== exp_bits[idx]) begin
                n_err++; $display("FAIL rb_bit%0d: got v%b d%b want v1 d%b", idx, rb_valid, rb_data, exp_bits[idx]);
            end
            if (rand_stall) rb_ready = ($urandom_range(99) < 60);
            else if (idx == 2 && stalls < 3) begin rb_ready = 1'b0; stalls++; end
            else rb_ready = 1'b1;
            prev = rb_data;
            @(negedge clk);
            cyc++;
            if (rb_ready) idx++;
            else begin
                n_vec++; if (rb_data !== prev) begin n_err++; $display("FAIL rb_hold: got %b want %b", rb_data, prev); end
            end
        end
        rb_ready = 1'b0;
        n_vec++; if (idx != W) begin n_err++; $display("FAIL rb_timeout: got %0d bits want %0d", idx, W); end
        n_vec++; if (rb_valid !== 1'b0) begin n_err++; $display("FAIL rb_end_valid: got %b want 0", rb_valid); end
        n_vec++; if (cfg_bits !== exp_bits || cfg_done !== exp_done) begin
            n_err++; $display("FAIL rb_side_effect: got %h/%b want %h/%b", cfg_bits, cfg_done, exp_bits, exp_done);
        end
    endtask

    task automatic test_start_priority_and_reset();
        @(negedge clk); cfg_start = 1'b1; rb_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0; rb_start = 1'b0;
        n_vec++; if (cfg_ready !== 1'b1 || rb_valid !== 1'b0) begin
            n_err++; $display("FAIL start_priority: got ready %b rbv %b want 1 0", cfg_ready, rb_valid);
        end
        send_bits(8'hFF, 3, 0);
        n_vec++; if (cfg_bits !== exp_bits) begin n_err++; $display("FAIL pre_reset_bits: got %h want %h", cfg_bits, exp_bits); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({cfg_bits, cfg_done, cfg_ready, cfg_out, rb_valid, rb_data} !== 13'b0) begin
            n_err++; $display("FAIL async_reset: got %h %b want 00 00000", cfg_bits, {cfg_done, cfg_ready, cfg_out, rb_valid, rb_data});
        end
        @(negedge clk); rst_n = 1'b1;
        exp_bits = '0;
    endtask

    task automatic test_chain();
        logic [W-1:0] s0 = 8'($urandom), s1 = 8'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk); a_start = 1'b1;
            @(negedge clk); a_start = 1'b0;
            for (int i = 0; i < W; i++) begin
                a_valid = 1'b1; a_in = (pass == 0) ? s0[i] : s1[i];
                @(negedge clk);
            end
            a_valid = 1'b0;
            @(negedge clk);
            n_vec++; if (a_bits !== ((pass == 0) ? s0 : s1) || a_done !== 1'b1) begin
                n_err++; $display("FAIL chain_a pass%0d: got %h/%b want %h/1", pass, a_bits, a_done, (pass == 0) ? s0 : s1);
            end
            n_vec++; if (b_done !== 1'b0) begin n_err++; $display("FAIL chain_b_early pass%0d: got %b want 0", pass, b_done); end
            @(negedge clk);
            n_vec++; if (b_bits !== ((pass == 0) ? 8'h00 : s0) || b_done !== 1'b1) begin
                n_err++; $display("FAIL chain_b pass%0d: got %h/%b want %h/1", pass, b_bits, b_done, (pass == 0) ? 8'h00 : s0);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_random();
        bit q[$];
        for (int it = 0; it < 8; it++) begin
            q.delete();
            for (int i = 0; i < W; i++) q.push_back(bit'($urandom));
            do_start();
            send_bits(pack_stream(q), W, 35);
            @(negedge clk);
            exp_bits = pack_stream(q);
            n_vec++; if (cfg_bits !== exp_bits || cfg_done !== 1'b1) begin
                n_err++; $display("FAIL rand_load%0d: got %h/%b want %h/1", it, cfg_bits, cfg_done, exp_bits);
            end
            test_readback(1'b1, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_in = 1'b0; cfg_valid = 1'b0;
        rb_start = 1'b0; rb_ready = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_in = 1'b0;
        exp_bits = '0;
        test_reset();
        test_load_continuous();
        test_load_gapped();
        test_abort();
        test_readback(1'b0, 1'b0);
        test_start_priority_and_reset();
        test_chain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
